// File: rtl/dp_mul_result_buffer_if.sv
// Result handshake bundle between the DP multiplier, the result buffer and its consumer.
// master = producer/consumer side (bench or datapath), slave = the buffer itself.
interface dp_mul_result_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_invalid;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;

    modport master (
        output in_valid, in_result, in_invalid, in_overflow, in_underflow, in_inexact, in_tag,
        output out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_tag
    );

    modport slave (
        input  in_valid, in_result, in_invalid, in_overflow, in_underflow, in_inexact, in_tag,
        input  out_ready,
        output in_ready, out_valid, out_result, out_flags, out_tag
    );
endinterface

// File: rtl/dp_mul_result_buffer.sv
// In-order FIFO of DP multiplier results with sticky exception flags accrued at pop.
// Push-to-out_valid latency 1 cycle; in_ready drops when full (no write-through, no read-through).
module dp_mul_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    dp_mul_result_buffer_if.slave      rb,
    input  logic                       flush,
    input  logic                       fflags_clr,
    output logic [4:0]                 fflags,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] result;
        logic [3:0]  tag;
        logic [4:0]  flags;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    entry_t        in_entry;
    entry_t        head;
    logic          push;
    logic          pop;

    // Flag order {NV,DZ,OF,UF,NX}; a multiply never divides by zero.
    assign in_entry = '{result: rb.in_result,
                        tag:    rb.in_tag,
                        flags:  {rb.in_invalid, 1'b0, rb.in_overflow, rb.in_underflow, rb.in_inexact}};

    assign head         = mem[rd_ptr];
    assign rb.in_ready  = (count != FULL);
    assign rb.out_valid = (count != '0);
    assign rb.out_result = head.result;
    assign rb.out_tag    = head.tag;
    assign rb.out_flags  = head.flags;

    assign push = rb.in_valid & rb.in_ready;
    assign pop  = rb.out_valid & rb.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Discarded entries never commit, so sticky flags are left alone.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Flags commit with the entry; a same-cycle clear happens before the accrue.
            if (pop) begin
                fflags <= (fflags_clr ? 5'b0 : fflags) | head.flags;
            end else if (fflags_clr) begin
                fflags <= '0;
            end
        end
    end
endmodule

// File: doc/dp_mul_result_buffer.md
DP_MUL_RESULT_BUFFER -- requirements
Module: dp_mul_result_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  multiplier result present this cycle.
REQ-005 Port: in_ready  output  1  buffer can accept a result this cycle.
REQ-006 Port: in_result  input  64  IEEE-754 double result from the DP multiplier.
REQ-007 Port: in_invalid, in_overflow, in_underflow, in_inexact  input  1 each  multiplier exception flags for in_result.
REQ-008 Port: in_tag  input  4  destination/issue tag carried alongside the result.
REQ-009 Port: flush  input  1  synchronous discard of all buffered entries.
REQ-010 Port: out_valid  output  1  head entry valid.
REQ-011 Port: out_ready  input  1  consumer accepts head entry.
REQ-012 Port: out_result  output  64  head entry result.
REQ-013 Port: out_flags  output  5  head entry flags {NV,DZ,OF,UF,NX}.
REQ-014 Port: out_tag  output  4  head entry tag.
REQ-015 Port: fflags  output  5  sticky accrued exception flags {NV,DZ,OF,UF,NX}.
REQ-016 Port: fflags_clr  input  1  clear sticky flags.
REQ-017 Port: count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-018 Push SHALL occur on in_valid & in_ready; pop SHALL occur on out_valid & out_ready.
REQ-019 in_ready SHALL equal (count != DEPTH); no write-through when full, even if popping the same cycle.
REQ-020 out_valid SHALL equal (count != 0); no read-through when empty; push-to-out_valid latency exactly 1 cycle.
REQ-021 Entry SHALL store {in_result, in_tag, flags} where flags = {in_invalid, 1'b0, in_overflow, in_underflow, in_inexact}; DZ is always 0.
REQ-022 out_result/out_flags/out_tag SHALL reflect head entry combinationally from storage; values are don't-care when out_valid=0 but SHALL NOT be X after reset (storage reset to 0).
REQ-023 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 Simultaneous push and pop (0<count<DEPTH): both pointers advance, count unchanged.
REQ-025 Push only: count+1; pop only: count-1; neither: count unchanged.
REQ-026 Order SHALL be strict FIFO; no reordering by tag.
REQ-027 flush SHALL set count and both pointers to 0 next cycle, override any push/pop that cycle, and leave fflags unchanged.
REQ-028 fflags SHALL accrue at pop (commit), not at push: fflags_next = fflags | out_flags on pop.
REQ-029 fflags_clr with no pop: fflags_next = 0.
REQ-030 fflags_clr with pop same cycle: fflags_next = out_flags of the popped entry (clear then accrue).
REQ-031 Entries discarded by flush SHALL NOT contribute to fflags.
REQ-032 in_valid while full SHALL be ignored; upstream must hold data (valid/ready protocol, no drop reported).

Reset
REQ-033 rst_n low SHALL immediately force count=0, pointers=0, out_valid=0, in_ready=1, fflags=0, all storage=0, regardless of clock.
REQ-034 Reset asserted mid-operation SHALL discard all entries; no pop or fflags update occurs in that cycle.
REQ-035 First push is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-036 Push in_result=64'h4000000000000000, flags 0, tag 4'h3; next cycle -> out_valid=1, out_result=64'h4000000000000000, out_tag=3, out_flags=0, count=1.
REQ-037 Push 4 entries tags 1..4 with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored; drain with out_ready=1 -> tags 1,2,3,4 in order, then out_valid=0.
REQ-038 count=2, push and pop same cycle -> count stays 2; at count=4 with pop and in_valid -> only pop, count=3.
REQ-039 Pop entry with in_inexact=1, then entry with in_overflow=1 -> fflags=5'b00101; then pop entry with in_invalid=1 plus fflags_clr -> fflags=5'b10000.
REQ-040 Push 3 entries (one in_invalid=1), assert flush -> count=0, out_valid=0, fflags unchanged (0).
REQ-041 Drop rst_n asynchronously between edges with count=3, fflags=5'b00001 -> immediately count=0, out_valid=0, in_ready=1, fflags=0.
